// File: rtl/fifo_ctrl_param.sv
// fifo_ctrl_param: parametrised single-clock FIFO. Contains the controller FSM,
// wrap-around pointers, an occupancy counter and the storage array in one block.
//
// Ports:
//   clk, rst       clock (rising edge), asynchronous active-high reset
//   clr            synchronous flush; returns to INIT, pointers, count and errors cleared
//   we, wdata      write request and data
//   re             read request
//   rdata, rvalid  registered read data; rvalid pulses one cycle per accepted read
//   full, empty    count == DEPTH, count == 0 (registered)
//   almost_full    count >= AF_LEVEL (registered)
//   almost_empty   count <= AE_LEVEL (registered)
//   count          occupancy 0..DEPTH
//   overflow       sticky: a write was dropped while full
//   underflow      sticky: a read was dropped while empty
module fifo_ctrl_param #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned AF_LEVEL = 12,
    parameter int unsigned AE_LEVEL = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              we,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int unsigned     DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_CNT = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0] AF_CNT    = AF_LEVEL[ADDR_W:0];
    localparam logic [ADDR_W:0] AE_CNT    = AE_LEVEL[ADDR_W:0];
    localparam logic [ADDR_W:0] CNT_ONE   = 1;
    localparam logic [ADDR_W-1:0] PTR_ONE = 1;

    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                full_q, empty_q, afull_q, aempty_q;
    logic                full_d, empty_d, afull_d, aempty_d;
    logic                ovf_q, ovf_d, unf_q, unf_d;
    logic                rvalid_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic in_run;
    logic wr_acc;
    logic rd_acc;

    // Acceptance uses the registered (pre-edge) flags only, so no path from
    // we/re reaches an output combinationally.
    assign in_run = (state_q == StRun) && !clr;
    assign wr_acc = in_run && we && !full_q;
    assign rd_acc = in_run && re && !empty_q;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;

        if (clr) begin
            state_d  = StInit;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else begin
            unique case (state_q)
                StInit: state_d = StRun;
                StRun: begin
                    if (we && full_q)  ovf_d = 1'b1;
                    if (re && empty_q) unf_d = 1'b1;
                    if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
                    if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
                    unique case ({wr_acc, rd_acc})
                        2'b10:   count_d = count_q + CNT_ONE;
                        2'b01:   count_d = count_q - CNT_ONE;
                        default: count_d = count_q;
                    endcase
                end
                default: state_d = StInit;
            endcase
        end

        // Flags follow next-count so they line up with count after the edge.
        full_d   = (count_d == DEPTH_CNT);
        empty_d  = (count_d == '0);
        afull_d  = (count_d >= AF_CNT);
        aempty_d = (count_d <= AE_CNT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StInit;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            rvalid_q <= rd_acc;
            if (rd_acc) rdata_q <= mem[rd_ptr_q];
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr_q] <= wdata;
    end

    assign rdata        = rdata_q;
    assign rvalid       = rvalid_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_fifo_ctrl_param.sv
// tb_fifo_ctrl_param: self-checking bench for fifo_ctrl_param. A behavioural
// model tracks FIFO contents; words leaving the model on an accepted read are
// pushed to a scoreboard queue and popped when the DUT raises rvalid.
module tb_fifo_ctrl_param;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned ADDR_W   = 4;
    localparam int unsigned DEPTH    = 16;
    localparam int unsigned AF_LEVEL = 12;
    localparam int unsigned AE_LEVEL = 2;

    logic              clk;
    logic              rst;
    logic              clr;
    logic              we;
    logic [DATA_W-1:0] wdata;
    logic              re;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;

    fifo_ctrl_param #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .AF_LEVEL(AF_LEVEL),
        .AE_LEVEL(AE_LEVEL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clr         (clr),
        .we          (we),
        .wdata       (wdata),
        .re          (re),
        .rdata       (rdata),
        .rvalid      (rvalid),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state
    bit                m_run    = 1'b0;
    bit                m_ovf    = 1'b0;
    bit                m_unf    = 1'b0;
    bit                m_rvalid = 1'b0;
    logic [DATA_W-1:0] m_rdata  = '0;
    logic [DATA_W-1:0] m_fifo[$];
    logic [DATA_W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        int sz;
        sz = m_fifo.size();
        check("count",        32'(count),        32'(sz));
        check("full",         32'(full),         32'(sz == DEPTH));
        check("empty",        32'(empty),        32'(sz == 0));
        check("almost_full",  32'(almost_full),  32'(sz >= AF_LEVEL));
        check("almost_empty", 32'(almost_empty), 32'(sz <= AE_LEVEL));
        check("overflow",     32'(overflow),     32'(m_ovf));
        check("underflow",    32'(underflow),    32'(m_unf));
        check("rvalid",       32'(rvalid),       32'(m_rvalid));
        if (rvalid === 1'b1) begin
            if (exp_q.size() == 0) check("rvalid_no_pending", 32'(rvalid), 32'(0));
            else m_rdata = exp_q.pop_front();
        end
        check("rdata", 32'(rdata), 32'(m_rdata));
    endtask

    // Drive one cycle, advance the model on pre-edge state, then check after the edge.
    task automatic step(input bit c, input bit w, input logic [DATA_W-1:0] d, input bit r);
        bit wa, ra;
        clr = c; we = w; wdata = d; re = r;
        if (c) begin
            m_run = 1'b0;
            m_fifo.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
            m_rvalid = 1'b0;
        end else if (!m_run) begin
            m_run = 1'b1;
            m_rvalid = 1'b0;
        end else begin
            wa = w && (m_fifo.size() < DEPTH);
            ra = r && (m_fifo.size() > 0);
            if (w && !wa) m_ovf = 1'b1;
            if (r && !ra) m_unf = 1'b1;
            if (ra) exp_q.push_back(m_fifo.pop_front());
            if (wa) m_fifo.push_back(d);
            m_rvalid = ra;
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; clr = 1'b0; we = 1'b0; wdata = '0; re = 1'b0;
        #2;
        check_outputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Write during INIT is ignored; next write lands.
        step(1'b0, 1'b1, 8'hAA, 1'b0);
        step(1'b0, 1'b1, 8'hBB, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);
        idle();

        // Fill 0x00..0x0F, then one more write overflows.
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'(i), 1'b0);
        step(1'b0, 1'b1, 8'h55, 1'b0);

        // Drain in order, then one extra read underflows.
        for (int i = 0; i < 16; i++) step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);
        idle();

        // Steady-state simultaneous read/write at count 5 across pointer wrap.
        step(1'b1, 1'b0, '0, 1'b0);
        idle();
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'(8'h20 + i), 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 8'(8'h40 + i), 1'b1);

        // Full with we & re: read accepted, write dropped.
        for (int i = 0; i < 11; i++) step(1'b0, 1'b1, 8'(8'h80 + i), 1'b0);
        step(1'b0, 1'b1, 8'hEE, 1'b1);
        idle();

        // Empty with we & re: write accepted, read dropped.
        step(1'b1, 1'b0, '0, 1'b0);
        idle();
        step(1'b0, 1'b1, 8'h77, 1'b1);
        idle();

        // count 10 with overflow set, then clr together with we.
        step(1'b1, 1'b0, '0, 1'b0);
        idle();
        for (int i = 0; i < 17; i++) step(1'b0, 1'b1, 8'(8'hC0 + i), 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0, 1'b1);
        step(1'b1, 1'b1, 8'h11, 1'b0);
        step(1'b0, 1'b1, 8'h12, 1'b0);
        step(1'b0, 1'b1, 8'h13, 1'b0);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 2) != 0),
                 8'($urandom), ($urandom_range(0, 2) != 0));
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
